// File: rtl/cnt_5_pkg.sv
// Shared constants and state codes for the modulo-5 up/down counter.
package cnt_5_pkg;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MOD = 5;

  typedef enum logic [CNT_W-1:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

  // Highest legal code; anything above it is an illegal state.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MOD - 1);

endpackage

// File: rtl/cnt5_ns_logic.sv
// Combinational next state for the modulo-5 counter, with recovery from
// the unused codes 5..7 back to S0.
module cnt5_ns_logic
  import cnt_5_pkg::*;
(
  input  logic [CNT_W-1:0] state,
  input  logic             inc,
  output logic [CNT_W-1:0] next
);

  always_comb begin
    // NOTE: assigning a default first means every path writes next, so no latch is inferred.
    next = S0;
    if (state > CNT_MAX) begin
      next = S0;
    end else if (inc) begin
      next = (state == CNT_MAX) ? S0 : state + 3'd1;
    end else begin
      next = (state == S0) ? CNT_MAX : state - 3'd1;
    end
  end

endmodule

// File: rtl/cnt5_state_reg.sv
// 3-bit state register with asynchronous active-high clear to S0.
module cnt5_state_reg
  import cnt_5_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking keeps the update ordered against every other flop on this edge.
    if (rst) begin
      q <= S0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/cnt_5.sv
// Modulo-5 up/down Moore counter; cnt is the state register itself.
// reset_n is active-high despite its name.
module cnt_5
  import cnt_5_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] state;
  logic [CNT_W-1:0] next_state;

  cnt5_ns_logic u_ns (
    .state (state),
    .inc   (inc),
    .next  (next_state)
  );

  cnt5_state_reg u_reg (
    .clk (clk),
    .rst (reset_n),
    .d   (next_state),
    .q   (state)
  );

  assign cnt = state;

endmodule

// File: tb/tb_cnt_5.sv
// Self-checking bench for cnt_5: directed sequences, forced illegal states,
// randomized direction with async reset pulses, and exhaustive next-state checks.
module tb_cnt_5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inc;
  logic [2:0] cnt;

  logic [2:0] ns_state;
  logic       ns_inc;
  logic [2:0] ns_next;

  int n_checks = 0;
  int n_pass   = 0;
  int model    = 0;

  cnt_5 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc),
    .cnt     (cnt)
  );

  cnt5_ns_logic u_ns_chk (
    .state (ns_state),
    .inc   (ns_inc),
    .next  (ns_next)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: cyclic index over 0..4, anything outside goes back to 0.
  function automatic int ref_next(input int s, input bit up);
    if (s < 0 || s > 4) return 0;
    return up ? (s + 1) % 5 : (s + 4) % 5;
  endfunction

  // Called #1 after a rising edge; drives inc, takes one edge, checks.
  task automatic step_exp(input bit up, input int exp, input string tag);
    inc = up;
    @(posedge clk);
    model = ref_next(model, up);
    #1;
    check(tag, int'(cnt), exp);
  endtask

  task automatic step(input bit up, input string tag);
    inc = up;
    @(posedge clk);
    model = ref_next(model, up);
    #1;
    check(tag, int'(cnt), model);
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 1'b1;
    #1;
    check(tag, int'(cnt), 0);
    #1;
    reset_n = 1'b0;
    model   = 0;
  endtask

  int up_exp  [6]  = '{1, 2, 3, 4, 0, 1};
  int dn_exp  [6]  = '{4, 3, 2, 1, 0, 4};
  bit mix_inc [10] = '{1, 1, 0, 1, 0, 1, 1, 0, 0, 1};
  int mix_exp [10] = '{1, 2, 1, 2, 1, 2, 3, 2, 1, 2};

  initial begin
    reset_n  = 1'b0;
    inc      = 1'b0;
    ns_state = 3'd0;
    ns_inc   = 1'b0;

    // Async reset before any clock edge, then held across edges.
    #2 reset_n = 1'b1;
    #1 check("reset_async", int'(cnt), 0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", int'(cnt), 0);
    reset_n = 1'b0;
    model   = 0;

    for (int i = 0; i < 6; i++) step_exp(1'b1, up_exp[i], $sformatf("up_%0d", i));

    pulse_reset("reset_before_down");
    for (int i = 0; i < 6; i++) step_exp(1'b0, dn_exp[i], $sformatf("down_%0d", i));

    pulse_reset("reset_before_mix");
    for (int i = 0; i < 10; i++) step_exp(mix_inc[i], mix_exp[i], $sformatf("mix_%0d", i));

    // Mid-count reset overrides immediately; first up step afterwards gives 1.
    pulse_reset("reset_before_mid");
    for (int i = 0; i < 3; i++) step_exp(1'b1, i + 1, $sformatf("mid_up_%0d", i));
    pulse_reset("reset_mid");
    step_exp(1'b1, 1, "after_mid_reset");

    // Illegal-state recovery from 3'b110 in both directions.
    for (int d = 0; d < 2; d++) begin
      force dut.u_reg.q = 3'b110;
      #1;
      check($sformatf("illegal_forced_%0d", d), int'(cnt), 6);
      release dut.u_reg.q;
      model = 6;
      step_exp(d[0], 0, $sformatf("illegal_recover_inc%0d", d));
    end

    // Randomized direction with occasional async reset pulses between edges.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($sformatf("rand_reset_%0d", i));
      else step(1'($urandom_range(0, 1)), $sformatf("rand_%0d", i));
    end

    // Exhaustive next-state table including the three illegal codes.
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns_state = 3'(s);
        ns_inc   = u[0];
        #1;
        check($sformatf("ns_s%0d_inc%0d", s, u), int'(ns_next), ref_next(s, u[0]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
